weighted_arbiter: RTL and testbench
===================================

WEIGHTED_ARBITER -- requirements
Module: weighted_arbiter

Interface
REQ-001 Parameter PORTS, default 4, number of requesters (legal range 2..32).
REQ-002 Parameter WEIGHT_WIDTH, default 4, width of each per-port weight and of the credit counter.
REQ-003 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port resetn  input  1  asynchronous, active-low reset.
REQ-005 Port request  input  PORTS  per-port request, bit i = port i.
REQ-006 Port acknowledge  input  PORTS  per-port transfer-complete strobe.
REQ-007 Port weight  input  PORTS*WEIGHT_WIDTH  flat per-port weight; port i at bits [i*WEIGHT_WIDTH +: WEIGHT_WIDTH].
REQ-008 Port grant  output  PORTS  one-hot grant, registered.
REQ-009 Port grant_valid  output  1  grant holds a valid port, registered.
REQ-010 Port grant_encoded  output  $clog2(PORTS)  binary index of the granted port, registered.
REQ-011 Port credit  output  WEIGHT_WIDTH  grants left in the current turn, including the one in progress.

Function
REQ-012 The block SHALL be a blocking, acknowledge-released, weighted round-robin arbiter with a 2-state FSM: IDLE (no grant) and GRANT (grant_valid=1).
REQ-013 IDLE: if any request bit is high, SHALL select a port by round-robin search and enter GRANT on the next edge (1-cycle latency); otherwise stay IDLE.
REQ-014 Round-robin search: the first requesting port at index >= ptr, wrapping past PORTS-1 to 0; ptr is a $clog2(PORTS)-bit register.
REQ-015 On a new turn for port i, credit SHALL load max(weight[i],1); a weight of 0 is treated as 1.
REQ-016 Weight SHALL be sampled only at turn start; weight changes mid-turn SHALL NOT affect credit.
REQ-017 GRANT: grant, grant_encoded and credit SHALL hold until acknowledge[grant_encoded]=1; dropping request[i] without acknowledge SHALL NOT release the grant.
REQ-018 Acknowledge bits of non-granted ports, and any acknowledge while in IDLE, SHALL be ignored.
REQ-019 On acknowledge with credit>1 and request[i]=1, SHALL re-grant port i on the next edge with credit-1, ptr unchanged, grant_valid staying 1 (no bubble).
REQ-020 On acknowledge with credit==1 or request[i]=0, SHALL set ptr=(i+1) mod PORTS and run the search in the same cycle with the new ptr.
REQ-021 After REQ-020: a search hit SHALL issue a new grant next cycle with fresh credit per REQ-015 (port i may win again if it is the only requester); a miss SHALL return to IDLE with grant=0, grant_encoded=0, credit=0.
REQ-022 grant SHALL always be one-hot or zero and consistent with grant_encoded; grant_valid=0 implies grant=0.

Reset
REQ-023 While resetn=0, grant=0, grant_valid=0, grant_encoded=0, credit=0, ptr=0, state=IDLE, asynchronously.
REQ-024 Reset asserted mid-grant SHALL drop the grant immediately; after release, the first grant follows REQ-013 with ptr=0.

Structure
REQ-025 Shared package arb_pkg SHALL hold the FSM state enum arb_state_t (IDLE, GRANT).
REQ-026 The search SHALL reuse the existing priority_encoder sub-module with LSB high priority, instantiated twice: once on request masked to indices >= ptr, once on raw request for the wrap case.

Verification (PORTS=4, WEIGHT_WIDTH=4)
REQ-027 Reset: resetn=0 with request=4'b1111 -> grant=0, grant_valid=0, credit=0; after release, grant=4'b0001 one cycle later.
REQ-028 Plain round robin: weights all 1, request=4'b1111, ack every grant cycle -> grant_encoded sequence 0,1,2,3,0, no idle cycles.
REQ-029 Weighted: weight0=3, weight1=1, request=4'b0011 held, ack every cycle -> sequence 0,0,0,1,0,0,0,1; credit 3,2,1,1,3.
REQ-030 Blocking: port 2 granted, no ack for 5 cycles, request2 dropped while request=4'b1011 -> grant stays 4'b0100; on ack, next grant is port 3.
REQ-031 Zero weight and mid-turn change: weight0=0 -> credit=1; weight0 changed 2 -> 5 after turn start -> turn still ends after 2 grants.
REQ-032 Async reset mid-turn (credit=2) -> outputs 0 with no clock edge; after release, request=4'b0100 -> grant=4'b0100 next cycle.

Source files
------------

// File: rtl/arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : arb_pkg
// Description : Shared types for the weighted round-robin arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package arb_pkg;

  // Arbiter FSM: IDLE holds no grant, GRANT owns a valid one-hot grant.
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

endpackage : arb_pkg
`default_nettype wire

// File: rtl/priority_encoder.sv
`default_nettype none
// ============================================================================
// Module      : priority_encoder
// Description : Returns the index of the lowest set bit (LSB = highest
//               priority) and a flag telling whether any bit was set.
// Revision    : 1.0 - initial release
// ============================================================================
module priority_encoder #(
  parameter int WIDTH = 4,
  parameter int IDX_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] req_i,
  output logic             valid_o,
  output logic [IDX_W-1:0] idx_o
);

  // Scan from MSB down so the lowest set index is the last one written.
  always_comb begin
    valid_o = |req_i;
    idx_o   = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (req_i[i]) idx_o = IDX_W'(i);
    end
  end

endmodule : priority_encoder
`default_nettype wire

// File: rtl/weighted_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : weighted_arbiter
// Description : Blocking, acknowledge-released weighted round-robin arbiter.
//               A port keeps the grant until it acknowledges; each turn gives
//               a port up to max(weight,1) back-to-back grants.
// Revision    : 1.0 - initial release
// ============================================================================
module weighted_arbiter
  import arb_pkg::*;
#(
  parameter int PORTS        = 4,
  parameter int WEIGHT_WIDTH = 4
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic [PORTS-1:0]              request,
  input  logic [PORTS-1:0]              acknowledge,
  input  logic [PORTS*WEIGHT_WIDTH-1:0] weight,
  output logic [PORTS-1:0]              grant,
  output logic                          grant_valid,
  output logic [$clog2(PORTS)-1:0]      grant_encoded,
  output logic [WEIGHT_WIDTH-1:0]       credit
);

  localparam int IDX_W = $clog2(PORTS);

  arb_state_t              state_q,  state_d;
  logic [IDX_W-1:0]        ptr_q,    ptr_d;
  logic [IDX_W-1:0]        enc_q,    enc_d;
  logic [PORTS-1:0]        grant_q,  grant_d;
  logic [WEIGHT_WIDTH-1:0] credit_q, credit_d;

  logic [IDX_W-1:0]        next_ptr;
  logic [IDX_W-1:0]        search_ptr;
  logic [PORTS-1:0]        search_mask;
  logic [PORTS-1:0]        masked_req;
  logic                    masked_valid, raw_valid, hit;
  logic [IDX_W-1:0]        masked_idx,   raw_idx,   hit_idx;
  logic [WEIGHT_WIDTH-1:0] sel_weight,   fresh_credit;

  // Pointer for the search: current ptr in IDLE, post-release ptr in GRANT so
  // a finishing turn can hand over to the next port without a bubble.
  always_comb begin
    next_ptr   = (enc_q == IDX_W'(PORTS - 1)) ? '0 : enc_q + IDX_W'(1);
    search_ptr = (state_q == GRANT) ? next_ptr : ptr_q;
  end

  // Mask keeps only requesters at or above the search pointer.
  always_comb begin
    search_mask = '0;
    for (int i = 0; i < PORTS; i++) begin
      search_mask[i] = (IDX_W'(i) >= search_ptr);
    end
  end

  assign masked_req = request & search_mask;

  priority_encoder #(
    .WIDTH (PORTS),
    .IDX_W (IDX_W)
  ) u_pe_masked (
    .req_i   (masked_req),
    .valid_o (masked_valid),
    .idx_o   (masked_idx)
  );

  priority_encoder #(
    .WIDTH (PORTS),
    .IDX_W (IDX_W)
  ) u_pe_raw (
    .req_i   (request),
    .valid_o (raw_valid),
    .idx_o   (raw_idx)
  );

  // Wrap to the raw search only when nothing sits at or above the pointer.
  always_comb begin
    hit          = masked_valid | raw_valid;
    hit_idx      = masked_valid ? masked_idx : raw_idx;
    sel_weight   = weight[hit_idx*WEIGHT_WIDTH +: WEIGHT_WIDTH];
    fresh_credit = (sel_weight == '0) ? WEIGHT_WIDTH'(1) : sel_weight;
  end

  // Next-state and next-output logic; everything holds unless changed below.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    enc_d    = enc_q;
    grant_d  = grant_q;
    credit_d = credit_q;
    case (state_q)
      IDLE: begin
        if (hit) begin
          state_d  = GRANT;
          enc_d    = hit_idx;
          grant_d  = PORTS'(1) << hit_idx;
          credit_d = fresh_credit;
        end
      end
      GRANT: begin
        if (acknowledge[enc_q]) begin
          if ((credit_q > WEIGHT_WIDTH'(1)) && request[enc_q]) begin
            credit_d = credit_q - WEIGHT_WIDTH'(1);
          end else begin
            ptr_d = next_ptr;
            if (hit) begin
              enc_d    = hit_idx;
              grant_d  = PORTS'(1) << hit_idx;
              credit_d = fresh_credit;
            end else begin
              state_d  = IDLE;
              enc_d    = '0;
              grant_d  = '0;
              credit_d = '0;
            end
          end
        end
      end
      default: begin
        state_d  = IDLE;
        enc_d    = '0;
        grant_d  = '0;
        credit_d = '0;
      end
    endcase
  end

  // State and output registers, cleared asynchronously by resetn.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      enc_q    <= '0;
      grant_q  <= '0;
      credit_q <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      enc_q    <= enc_d;
      grant_q  <= grant_d;
      credit_q <= credit_d;
    end
  end

  assign grant         = grant_q;
  assign grant_valid   = (state_q == GRANT);
  assign grant_encoded = enc_q;
  assign credit        = credit_q;

endmodule : weighted_arbiter
`default_nettype wire

// File: tb/tb_weighted_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_weighted_arbiter
// Description : Directed self-checking bench for weighted_arbiter
//               (PORTS=4, WEIGHT_WIDTH=4) using an expected-output queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_weighted_arbiter;

  logic        clk;
  logic        resetn;
  logic [3:0]  request;
  logic [3:0]  acknowledge;
  logic [15:0] weight;
  logic [3:0]  grant;
  logic        grant_valid;
  logic [1:0]  grant_encoded;
  logic [3:0]  credit;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic       v;
    logic [1:0] enc;
    logic [3:0] cr;
  } exp_t;

  exp_t sb[$];

  weighted_arbiter #(
    .PORTS        (4),
    .WEIGHT_WIDTH (4)
  ) dut (
    .clk           (clk),
    .resetn        (resetn),
    .request       (request),
    .acknowledge   (acknowledge),
    .weight        (weight),
    .grant         (grant),
    .grant_valid   (grant_valid),
    .grant_encoded (grant_encoded),
    .credit        (credit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: run did not finish, observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic push(input logic v, input logic [1:0] e, input logic [3:0] c);
    exp_t x;
    x.v = v; x.enc = e; x.cr = c;
    sb.push_back(x);
  endtask

  // Pop one expected entry and compare all four outputs against it.
  task automatic check_one(input string tag);
    exp_t       x;
    logic [3:0] eg;
    x  = sb.pop_front();
    eg = x.v ? (4'b0001 << x.enc) : 4'b0000;
    n_cmp++;
    assert (grant === eg) else begin
      n_err++;
      $error("FAIL %s grant observed=%b expected=%b", tag, grant, eg);
    end
    n_cmp++;
    assert (grant_valid === x.v) else begin
      n_err++;
      $error("FAIL %s grant_valid observed=%b expected=%b", tag, grant_valid, x.v);
    end
    n_cmp++;
    assert (grant_encoded === x.enc) else begin
      n_err++;
      $error("FAIL %s grant_encoded observed=%0d expected=%0d", tag, grant_encoded, x.enc);
    end
    n_cmp++;
    assert (credit === x.cr) else begin
      n_err++;
      $error("FAIL %s credit observed=%0d expected=%0d", tag, credit, x.cr);
    end
  endtask

  // One clock: queue the expectation, take the edge, compare just after it.
  task automatic cyc(input string tag, input logic v, input logic [1:0] e, input logic [3:0] c);
    push(v, e, c);
    @(posedge clk);
    #1;
    check_one(tag);
  endtask

  // Compare without any clock edge (asynchronous behaviour).
  task automatic now_check(input string tag, input logic v, input logic [1:0] e, input logic [3:0] c);
    push(v, e, c);
    check_one(tag);
  endtask

  // Short reset pulse placed between clock edges.
  task automatic do_reset();
    resetn = 1'b0;
    #1;
    now_check("rst_pulse", 1'b0, 2'd0, 4'd0);
    #1;
    resetn = 1'b1;
  endtask

  initial begin
    resetn      = 1'b0;
    request     = 4'b1111;
    acknowledge = 4'b0000;
    weight      = {4'd1, 4'd1, 4'd1, 4'd1};

    // Reset with all requests high, then first grant one cycle after release
    #12;
    now_check("reset_hold", 1'b0, 2'd0, 4'd0);
    resetn = 1'b1;
    cyc("rst_first", 1'b1, 2'd0, 4'd1);

    // Plain round robin, acknowledge every cycle
    acknowledge = 4'b1111;
    cyc("rr_1", 1'b1, 2'd1, 4'd1);
    cyc("rr_2", 1'b1, 2'd2, 4'd1);
    cyc("rr_3", 1'b1, 2'd3, 4'd1);
    cyc("rr_0", 1'b1, 2'd0, 4'd1);
    request = 4'b0000;
    cyc("rr_idle", 1'b0, 2'd0, 4'd0);
    cyc("idle_ack_ignored", 1'b0, 2'd0, 4'd0);

    // Weighted: w0=3, w1=1, ack held high (ignored while idle)
    do_reset();
    weight  = {4'd1, 4'd1, 4'd1, 4'd3};
    request = 4'b0011;
    cyc("wt_a0", 1'b1, 2'd0, 4'd3);
    cyc("wt_a1", 1'b1, 2'd0, 4'd2);
    cyc("wt_a2", 1'b1, 2'd0, 4'd1);
    cyc("wt_b",  1'b1, 2'd1, 4'd1);
    cyc("wt_c0", 1'b1, 2'd0, 4'd3);
    cyc("wt_c1", 1'b1, 2'd0, 4'd2);
    cyc("wt_c2", 1'b1, 2'd0, 4'd1);
    cyc("wt_d",  1'b1, 2'd1, 4'd1);
    request = 4'b0000;
    cyc("wt_idle", 1'b0, 2'd0, 4'd0);

    // Blocking: port 2 holds through dropped request and foreign acks
    do_reset();
    weight      = {4'd1, 4'd1, 4'd1, 4'd1};
    acknowledge = 4'b0000;
    request     = 4'b0100;
    cyc("blk_start", 1'b1, 2'd2, 4'd1);
    request     = 4'b1011;
    acknowledge = 4'b1011;
    for (int k = 0; k < 5; k++) cyc("blk_hold", 1'b1, 2'd2, 4'd1);
    acknowledge = 4'b0100;
    cyc("blk_next", 1'b1, 2'd3, 4'd1);
    acknowledge = 4'b0000;
    request     = 4'b0000;
    cyc("blk_noack", 1'b1, 2'd3, 4'd1);
    acknowledge = 4'b1111;
    cyc("blk_idle", 1'b0, 2'd0, 4'd0);

    // Zero weight maps to one grant
    do_reset();
    weight      = {4'd1, 4'd1, 4'd1, 4'd0};
    acknowledge = 4'b0000;
    request     = 4'b0001;
    cyc("zw_start", 1'b1, 2'd0, 4'd1);
    acknowledge = 4'b0001;
    request     = 4'b0000;
    cyc("zw_idle", 1'b0, 2'd0, 4'd0);

    // Weight raised mid-turn: turn still ends after 2 grants
    weight      = {4'd1, 4'd1, 4'd1, 4'd2};
    acknowledge = 4'b0000;
    request     = 4'b0001;
    cyc("mt_start", 1'b1, 2'd0, 4'd2);
    weight      = {4'd1, 4'd1, 4'd1, 4'd5};
    acknowledge = 4'b0001;
    cyc("mt_second", 1'b1, 2'd0, 4'd1);
    cyc("mt_newturn", 1'b1, 2'd0, 4'd5);
    request = 4'b0000;
    cyc("mt_drop_release", 1'b0, 2'd0, 4'd0);

    // Async reset mid-turn with credit 2
    do_reset();
    weight      = {4'd1, 4'd2, 4'd1, 4'd1};
    acknowledge = 4'b0000;
    request     = 4'b0100;
    cyc("ar_start", 1'b1, 2'd2, 4'd2);
    #2;
    resetn = 1'b0;
    #1;
    now_check("ar_async", 1'b0, 2'd0, 4'd0);
    #1;
    resetn = 1'b1;
    cyc("ar_regrant", 1'b1, 2'd2, 4'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_weighted_arbiter
`default_nettype wire
